shared_reg_arbiter: RTL and testbench
=====================================

# shared_reg_arbiter

Round-robin arbiter and write sequencer for one shared WIDTH-bit register bank built from enable/reset master-slave D flip-flops. Two requesters compete for write access. The arbiter grants one requester, drives the bank's data and enable for exactly one capture edge, then reads the bank output back to confirm the write. Requesters see a one-cycle done or error pulse, and the bank itself stays a plain storage element.

## Interface
- WIDTH, 4: bits in the shared register bank.
- MAX_RETRY, 2: extra write attempts after a readback mismatch before error is flagged (0..7).
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- req  in  2  per-requester write request; level, held until done or err for that requester.
- wr_data0  in  WIDTH  write value from requester 0; sampled on grant.
- wr_data1  in  WIDTH  write value from requester 1; sampled on grant.
- reg_q  in  WIDTH  current Q of the register bank.
- reg_d  out  WIDTH  data to bank D inputs.
- reg_en  out  1  bank enable; high for exactly one cycle per attempt.
- grant  out  2  one-hot owner of the bank; 00 when idle.
- done  out  2  one-cycle pulse to the owner on a verified write.
- err  out  2  one-cycle pulse to the owner when retries are exhausted.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, WRITE, CHECK, RESP.
- IDLE
  - If no req, stay in IDLE.
  - If only one req is set, grant it.
  - If both are set, grant the requester indicated by priority pointer ptr (reset value 0).
  - On grant, latch the owner's wr_data into hold_data, clear the retry count, and go to WRITE.
- WRITE
  - reg_d = hold_data, reg_en = 1.
  - Next state is CHECK.
- CHECK
  - reg_en = 0. reg_q is compared to hold_data.
  - On a match, go to RESP with status ok.
  - On a mismatch with retry count < MAX_RETRY, increment the count and return to WRITE.
  - Otherwise go to RESP with status fail.
- RESP
  - Assert done[owner] (ok) or err[owner] (fail) for this cycle.
  - Set ptr to the other requester.
  - Clear grant and go to IDLE.
- grant is one-hot and stable from the cycle after the grant decision through RESP.
- reg_d holds hold_data in all non-IDLE states and 0 in IDLE.
- Retry count width is 3 bits; it never wraps because it is bounded by MAX_RETRY.
- If the owner drops req before RESP, the write still completes and the done/err pulse still fires. It is a protocol violation, but it must not hang the FSM.
- If wr_data changes after grant, it is ignored because hold_data is used.
- Reset values: state IDLE, grant 00, done 00, err 00, reg_en 0, reg_d 0, busy 0, ptr 0, retry count 0.
- Reset mid-operation: all outputs drop to their reset values asynchronously, and no done/err pulse is issued. reg_en falls immediately, so a capture in progress is abandoned.

## Timing
- Grant latency: req seen in IDLE at edge N gives grant and WRITE valid after edge N.
- reg_en is high from edge N to edge N+1; the bank captures at edge N+1.
- CHECK runs from edge N+1 to N+2 and compares the post-capture reg_q.
- With no retry, done is high from edge N+2 to N+3. Total latency from request to done is 3 cycles.
- Each retry adds 2 cycles.
- The earliest next grant decision is the IDLE cycle after RESP, giving a 4-cycle minimum turnaround per write.
- reg_en, grant, done, err and busy are registered outputs with no combinational path from req.
- reg_q is used only in CHECK.

## Structure
- Shared package holds:
  - state encoding constants ST_IDLE, ST_WRITE, ST_CHECK, ST_RESP (2-bit);
  - requester index constants REQ0 = 0, REQ1 = 1.
- One sub-module is natural: rr_pick. It is combinational; it takes req[1:0] and ptr and returns a one-hot winner and a valid signal.
- The FSM, hold register, retry counter and output registers live in shared_reg_arbiter.

## Test plan
- Single write, WIDTH = 4: after reset, req = 01 with wr_data0 = 4'hA and a bank model capturing at the reg_en edge.
  - Required: reg_en is high for 1 cycle with reg_d = A, done = 01 three cycles after the request, and grant returns to 00.
- Contention: req = 11 held continuously.
  - Required: grants alternate 01, 10, 01. The done pulses alternate owners with each write taking 4 cycles, and ptr toggles after each RESP.
- Retry then success: the bank model ignores the first reg_en. Requester 1 writes 4'h5.
  - Required: two reg_en pulses, done = 10 five cycles after the request, and err stays 00.
- Retry exhaustion, MAX_RETRY = 2: the bank model is stuck at 0 and requester 0 writes 4'hF.
  - Required: three reg_en pulses, then err = 01 for one cycle, and done never asserts.
- Async reset mid-write: assert reset low during WRITE.
  - Required: reg_en, grant and busy go to 0 in the same simulation time step with no done/err pulse. After release with req = 01, the write completes normally.
- Data stability: change wr_data0 from 3 to 9 the cycle after grant.
  - Required: reg_d = 3, the bank captures 3, and done = 01.

Source files
------------

// File: rtl/shared_reg_arbiter_pkg.sv
// Shared constants for the shared register bank arbiter: FSM state encoding and requester indices.
// Holds no logic.
package shared_reg_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_CHECK = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam int REQ0 = 0;
   localparam int REQ1 = 1;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Two-way round-robin pick, purely combinational (zero latency).
// Has no backpressure: a lone request always wins, and ptr breaks a tie.
module shared_reg_arbiter_rr_pick
   import shared_reg_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] win,
   output logic       vld
);

   always_comb begin
      win = 2'b00;
      if (req[REQ0] && (!req[REQ1] || !ptr))
         win[REQ0] = 1'b1;
      else if (req[REQ1])
         win[REQ1] = 1'b1;
   end

   assign vld = |req;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write sequencer for a shared register bank. A verified write pulses done 3 cycles after the request, and each retry adds 2 cycles.
// The owner is held off until the bank reads back its value. A loser keeps its req high until it is served.
module shared_reg_arbiter
   import shared_reg_arbiter_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MAX_RETRY = 2
)(
   input  logic             clock,
   input  logic             reset,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] wr_data0,
   input  logic [WIDTH-1:0] wr_data1,
   input  logic [WIDTH-1:0] reg_q,
   output logic [WIDTH-1:0] reg_d,
   output logic             reg_en,
   output logic [1:0]       grant,
   output logic [1:0]       done,
   output logic [1:0]       err,
   output logic             busy
);

   localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

   state_t           state;
   logic             ptr;
   logic [2:0]       retry_cnt;
   logic [WIDTH-1:0] hold_data;
   logic [1:0]       pick;
   logic             pick_vld;
   logic [WIDTH-1:0] pick_data;

   shared_reg_arbiter_rr_pick u_rr_pick (
      .req (req),
      .ptr (ptr),
      .win (pick),
      .vld (pick_vld)
   );

   assign pick_data = pick[REQ1] ? wr_data1 : wr_data0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         ptr       <= 1'b0;
         retry_cnt <= 3'd0;
         hold_data <= '0;
         reg_d     <= '0;
         reg_en    <= 1'b0;
         grant     <= 2'b00;
         done      <= 2'b00;
         err       <= 2'b00;
         busy      <= 1'b0;
      end else begin
         done <= 2'b00;
         err  <= 2'b00;
         case (state)
            ST_IDLE: begin
               if (pick_vld) begin
                  state     <= ST_WRITE;
                  grant     <= pick;
                  hold_data <= pick_data;
                  reg_d     <= pick_data;
                  reg_en    <= 1'b1;
                  retry_cnt <= 3'd0;
                  busy      <= 1'b1;
               end
            end
            ST_WRITE: begin
               state  <= ST_CHECK;
               reg_en <= 1'b0;
            end
            ST_CHECK: begin
               // The bank captured on the edge that entered CHECK, so reg_q is post-write.
               if (reg_q == hold_data) begin
                  state <= ST_RESP;
                  done  <= grant;
               end else if (retry_cnt < RETRY_LIMIT) begin
                  state     <= ST_WRITE;
                  retry_cnt <= retry_cnt + 3'd1;
                  reg_en    <= 1'b1;
               end else begin
                  state <= ST_RESP;
                  err   <= grant;
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
               ptr   <= grant[REQ0];
               grant <= 2'b00;
               reg_d <= '0;
               busy  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Randomized bench for shared_reg_arbiter. A transaction-level model predicts the winner, the attempt count and the outcome.
// The per-cycle output timeline is then checked against those predictions.
module tb_shared_reg_arbiter;

   localparam int WIDTH     = 4;
   localparam int MAX_RETRY = 2;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic [1:0]       req = 2'b00;
   logic [WIDTH-1:0] wr_data0 = '0;
   logic [WIDTH-1:0] wr_data1 = '0;
   logic [WIDTH-1:0] reg_q;
   logic [WIDTH-1:0] reg_d;
   logic             reg_en;
   logic [1:0]       grant;
   logic [1:0]       done;
   logic [1:0]       err;
   logic             busy;

   int errors = 0;
   int checks = 0;
   int m_ptr  = 0;

   // Bank model: skips the first 'drops' enables of the current transaction.
   logic [WIDTH-1:0] bank_q = '0;
   int en_total  = 0;
   int drop_base = 0;
   int drops     = 0;

   shared_reg_arbiter #(.WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY)) dut (
      .clock    (clock),
      .reset    (reset),
      .req      (req),
      .wr_data0 (wr_data0),
      .wr_data1 (wr_data1),
      .reg_q    (reg_q),
      .reg_d    (reg_d),
      .reg_en   (reg_en),
      .grant    (grant),
      .done     (done),
      .err      (err),
      .busy     (busy)
   );

   assign reg_q = bank_q;

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (reg_en) begin
         if (en_total - drop_base >= drops)
            bank_q <= reg_d;
         en_total <= en_total + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_grant"}, 32'(grant), 0);
      check_eq({tag, "_en"}, 32'(reg_en), 0);
      check_eq({tag, "_d"}, 32'(reg_d), 0);
      check_eq({tag, "_done"}, 32'(done), 0);
      check_eq({tag, "_err"}, 32'(err), 0);
      check_eq({tag, "_busy"}, 32'(busy), 0);
   endtask

   // Called one step after an edge that leaves the DUT in IDLE.
   task automatic run_txn(input logic [1:0] r, input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                          input int ndrop, input bit drop_early);
      int own;
      int att;
      int ok;
      int last;
      int on;
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] v;
      own = (r == 2'b01) ? 0 : (r == 2'b10) ? 1 : m_ptr;
      d   = (own == 1) ? d1 : d0;
      v   = bank_q;
      ok  = 0;
      att = 0;
      for (int a = 1; a <= MAX_RETRY + 1 && ok == 0; a++) begin
         att = a;
         if (a - 1 >= ndrop) v = d;
         if (v == d) ok = 1;
      end
      last = 2 * att + 1;

      req       = r;
      wr_data0  = d0;
      wr_data1  = d1;
      drop_base = en_total;
      drops     = ndrop;
      for (int k = 1; k <= last + 1; k++) begin
         @(posedge clock);
         #1;
         on = (k <= last) ? 1 : 0;
         check_eq("grant", 32'(grant), (on == 1) ? (1 << own) : 0);
         check_eq("reg_en", 32'(reg_en), (k % 2 == 1 && k < last) ? 1 : 0);
         check_eq("reg_d", 32'(reg_d), (on == 1) ? 32'(d) : 0);
         check_eq("busy", 32'(busy), on);
         check_eq("done", 32'(done), (ok == 1 && k == last) ? (1 << own) : 0);
         check_eq("err", 32'(err), (ok == 0 && k == last) ? (1 << own) : 0);
         if (k == 1) begin
            wr_data0 = 4'($urandom);
            wr_data1 = 4'($urandom);
            if (drop_early) req[own] = 1'b0;
         end
      end
      check_eq("bank", 32'(bank_q), 32'(v));
      m_ptr = 1 - own;
   endtask

   task automatic idle_cycles(input int n);
      req = 2'b00;
      repeat (n) begin
         @(posedge clock);
         #1;
         check_idle("idle");
      end
   endtask

   initial begin
      #2 reset = 1'b0;
      #6 check_idle("rst");
      @(posedge clock);
      #1 reset = 1'b1;

      run_txn(2'b01, 4'hA, 4'h0, 0, 1'b0);
      repeat (3) run_txn(2'b11, 4'h3, 4'h6, 0, 1'b0);
      run_txn(2'b10, 4'h0, 4'h5, 1, 1'b0);
      run_txn(2'b01, 4'hF, 4'h0, 7, 1'b0);
      run_txn(2'b01, 4'h3, 4'h0, 0, 1'b0);
      run_txn(2'b10, 4'h1, 4'h8, 0, 1'b1);
      idle_cycles(2);

      req       = 2'b10;
      wr_data1  = 4'hC;
      drop_base = en_total;
      drops     = 0;
      @(posedge clock);
      #1;
      check_eq("mid_en_pre", 32'(reg_en), 1);
      reset = 1'b0;
      #1;
      check_eq("mid_en", 32'(reg_en), 0);
      check_eq("mid_grant", 32'(grant), 0);
      check_eq("mid_busy", 32'(busy), 0);
      check_eq("mid_d", 32'(reg_d), 0);
      repeat (3) begin
         @(posedge clock);
         #1;
         check_idle("in_rst");
      end
      reset = 1'b1;
      m_ptr = 0;
      run_txn(2'b01, 4'h7, 4'h2, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         run_txn(2'($urandom_range(1, 3)), 4'($urandom), 4'($urandom),
                 int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 4) == 0) idle_cycles(int'($urandom_range(1, 2)));
      end
      idle_cycles(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
